// File: rtl/riscv_pc_ctrl.sv
// Fetch PC sequencer with pending-redirect buffer and trap/mret handling.
// Optional misaligned-branch trap when RISCV_PC_MISALIGN_TRAP_EN is defined.
module riscv_pc_ctrl #(
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'('h100)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            adv,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            trap,
  input  logic            mret,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] pc_4,
  output logic            pc_valid,
  output logic [PC_W-1:0] epc_out,
  output logic            misalign
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    PEND
  } state_e;

  // Encoding order doubles as priority: higher value wins.
  typedef enum logic [1:0] {
    K_NONE,
    K_BR,
    K_MRET,
    K_TRAP
  } kind_e;

  localparam logic [PC_W-1:0] ALIGN = ~PC_W'(3);

  state_e          state_q, state_d;
  kind_e           pk_q, pk_d;
  kind_e           req_k, app_k;
  logic [PC_W-1:0] pt_q, pt_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] epc_q, epc_d;
  logic [PC_W-1:0] tgt_in, app_t, nxt;
  logic            apply;

  always_comb begin
    req_k = K_NONE;
    if (trap) req_k = K_TRAP;
    else if (mret) req_k = K_MRET;
    else if (br_taken) req_k = K_BR;
  end

`ifdef RISCV_PC_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  assign tgt_in = br_target;
`else
  assign tgt_in = br_target & ALIGN;
`endif

  always_comb begin
    state_d = state_q;
    pk_d    = pk_q;
    pt_d    = pt_q;
    epc_d   = epc_q;
    apply   = 1'b0;
    app_k   = K_NONE;
    app_t   = tgt_in;
    nxt     = pc_q;
`ifdef RISCV_PC_MISALIGN_TRAP_EN
    mis_d   = 1'b0;
`endif
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (adv) begin
          apply = 1'b1;
          app_k = req_k;
        end else if (req_k != K_NONE) begin
          pk_d    = req_k;
          pt_d    = tgt_in;
          state_d = PEND;
        end
      end
      PEND: begin
        if (adv) begin
          apply   = 1'b1;
          pk_d    = K_NONE;
          state_d = RUN;
          if (req_k >= pk_q) begin
            app_k = req_k;
          end else begin
            app_k = pk_q;
            app_t = pt_q;
          end
        end else if (req_k != K_NONE && req_k >= pk_q) begin
          pk_d = req_k;
          pt_d = tgt_in;
        end
      end
      default: state_d = BOOT;
    endcase
    if (apply) begin
      unique case (app_k)
        K_TRAP: begin
          nxt   = TRAP_VEC;
          epc_d = pc_q;
        end
        K_MRET: nxt = epc_q;
        K_BR: begin
`ifdef RISCV_PC_MISALIGN_TRAP_EN
          if (app_t[1:0] != 2'b00) begin
            nxt   = TRAP_VEC;
            epc_d = pc_q;
            mis_d = 1'b1;
          end else begin
            nxt = app_t;
          end
`else
          nxt = app_t;
`endif
        end
        default: nxt = pc_q + PC_W'(4);
      endcase
    end
    pc_d = nxt & ALIGN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pk_q    <= K_NONE;
      pt_q    <= '0;
      pc_q    <= RESET_VEC & ALIGN;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      pk_q    <= pk_d;
      pt_q    <= pt_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
    end
  end

`ifdef RISCV_PC_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mis_q <= 1'b0;
    else       mis_q <= mis_d;
  end
  assign misalign = mis_q;
`else
  assign misalign = 1'b0;
`endif

  assign pc_out   = pc_q;
  assign pc_4     = pc_q + PC_W'(4);
  assign pc_valid = (state_q != BOOT);
  assign epc_out  = epc_q;

endmodule

// File: tb/tb_riscv_pc_ctrl.sv
// Directed scoreboard bench for riscv_pc_ctrl (32-bit and 16-bit builds).
// Misalign expectations follow RISCV_PC_MISALIGN_TRAP_EN.
module tb_riscv_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        adv = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        trap = 1'b0;
  logic        mret = 1'b0;
  logic [31:0] pc_out, pc_4, epc_out;
  logic        pc_valid, misalign;

  logic        b_adv = 1'b0;
  logic        b_zero = 1'b0;
  logic [15:0] b_tgt = '0;
  logic [15:0] b_pc, b_pc4, b_epc;
  logic        b_valid, b_mis;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] epc;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  riscv_pc_ctrl #(.PC_W(32)) dut (
    .clk(clk), .reset(reset), .adv(adv),
    .br_taken(br_taken), .br_target(br_target),
    .trap(trap), .mret(mret),
    .pc_out(pc_out), .pc_4(pc_4), .pc_valid(pc_valid),
    .epc_out(epc_out), .misalign(misalign)
  );

  riscv_pc_ctrl #(.PC_W(16), .RESET_VEC(16'hFFF8)) dut16 (
    .clk(clk), .reset(reset), .adv(b_adv),
    .br_taken(b_zero), .br_target(b_tgt),
    .trap(b_zero), .mret(b_zero),
    .pc_out(b_pc), .pc_4(b_pc4), .pc_valid(b_valid),
    .epc_out(b_epc), .misalign(b_mis)
  );

  task automatic push(input string tag, input logic [31:0] p,
                      input logic v, input logic [31:0] e,
                      input logic m);
    exp_t x;
    x.tag = tag; x.pc = p; x.pc4 = p + 32'd4;
    x.valid = v; x.epc = e; x.mis = m;
    sb.push_back(x);
  endtask

  task automatic pop_check();
    exp_t x;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty got 0 entries want 1");
      return;
    end
    x = sb.pop_front();
    checks++;
    assert (pc_out === x.pc) else begin
      errors++;
      $error("FAIL %s.pc got %h want %h", x.tag, pc_out, x.pc);
    end
    checks++;
    assert (pc_4 === x.pc4) else begin
      errors++;
      $error("FAIL %s.pc_4 got %h want %h", x.tag, pc_4, x.pc4);
    end
    checks++;
    assert (pc_valid === x.valid) else begin
      errors++;
      $error("FAIL %s.valid got %b want %b", x.tag, pc_valid, x.valid);
    end
    checks++;
    assert (epc_out === x.epc) else begin
      errors++;
      $error("FAIL %s.epc got %h want %h", x.tag, epc_out, x.epc);
    end
    checks++;
    assert (misalign === x.mis) else begin
      errors++;
      $error("FAIL %s.mis got %b want %b", x.tag, misalign, x.mis);
    end
  endtask

  task automatic step(input logic a, input logic b,
                      input logic [31:0] t, input logic tr,
                      input logic m, input string tag,
                      input logic [31:0] p, input logic [31:0] e,
                      input logic mi);
    adv = a; br_taken = b; br_target = t; trap = tr; mret = m;
    push(tag, p, 1'b1, e, mi);
    @(posedge clk);
    #1;
    adv = 1'b0; br_taken = 1'b0; trap = 1'b0; mret = 1'b0;
    pop_check();
  endtask

  task automatic chk16(input string tag, input logic [15:0] p,
                       input logic v);
    checks++;
    assert (b_pc === p && b_pc4 === p + 16'd4 && b_valid === v)
    else begin
      errors++;
      $error("FAIL %s got pc=%h pc4=%h v=%b want pc=%h pc4=%h v=%b",
             tag, b_pc, b_pc4, b_valid, p, p + 16'd4, v);
    end
  endtask

  initial begin
    logic [31:0] p;
    logic [31:0] e;
    #1 reset = 1'b1;
    #1;
    push("reset", 32'h0, 1'b0, 32'h0, 1'b0);
    pop_check();
    chk16("w16_reset", 16'hFFF8, 1'b0);
    #1 reset = 1'b0;
    b_adv = 1'b1;

    step(1, 0, 0, 0, 0, "boot", 32'h0, 32'h0, 0);
    chk16("w16_boot", 16'hFFF8, 1'b1);
    step(1, 0, 0, 0, 0, "seq4", 32'h4, 32'h0, 0);
    chk16("w16_fffc", 16'hFFFC, 1'b1);
    step(1, 0, 0, 0, 0, "seq8", 32'h8, 32'h0, 0);
    chk16("w16_wrap", 16'h0000, 1'b1);
    step(1, 0, 0, 0, 0, "seq12", 32'hC, 32'h0, 0);
    b_adv = 1'b0;

    step(1, 1, 32'h40, 0, 0, "br40", 32'h40, 32'h0, 0);
    step(0, 1, 32'h200, 0, 0, "pend_br", 32'h40, 32'h0, 0);
    step(0, 0, 0, 0, 0, "hold1", 32'h40, 32'h0, 0);
    step(0, 0, 0, 0, 0, "hold2", 32'h40, 32'h0, 0);
    step(1, 0, 0, 0, 0, "pend_go", 32'h200, 32'h0, 0);

    step(1, 1, 32'h80, 0, 0, "br80", 32'h80, 32'h0, 0);
    step(1, 1, 32'h300, 1, 0, "trap_br", 32'h100, 32'h80, 0);
    step(1, 0, 0, 0, 0, "trap_seq", 32'h104, 32'h80, 0);
    step(1, 0, 0, 0, 1, "mret", 32'h80, 32'h80, 0);
    step(1, 0, 0, 0, 0, "seq84", 32'h84, 32'h80, 0);

    step(0, 1, 32'h300, 0, 0, "pend300", 32'h84, 32'h80, 0);
    step(0, 0, 0, 1, 0, "pend_trap", 32'h84, 32'h80, 0);
    step(0, 1, 32'h400, 0, 0, "pend_low", 32'h84, 32'h80, 0);
    step(1, 0, 0, 0, 0, "pend_tgo", 32'h100, 32'h84, 0);

    step(0, 0, 0, 0, 1, "pend_mret", 32'h100, 32'h84, 0);
    step(1, 1, 32'h500, 0, 0, "mret_vs_br", 32'h84, 32'h84, 0);

    step(1, 1, 32'hFFFF_FFFC, 0, 0, "br_top", 32'hFFFF_FFFC, 32'h84, 0);
    step(1, 0, 0, 0, 0, "wrap32", 32'h0, 32'h84, 0);

`ifdef RISCV_PC_MISALIGN_TRAP_EN
    step(1, 1, 32'h202, 0, 0, "mis_br", 32'h100, 32'h0, 1);
    step(1, 0, 0, 0, 0, "mis_after", 32'h104, 32'h0, 0);
    p = 32'h104;
    e = 32'h0;
`else
    step(1, 1, 32'h202, 0, 0, "mis_br", 32'h200, 32'h84, 0);
    step(1, 0, 0, 0, 0, "mis_after", 32'h204, 32'h84, 0);
    p = 32'h204;
    e = 32'h84;
`endif

    step(0, 1, 32'h600, 0, 0, "pend600", p, e, 0);
    #2 reset = 1'b1;
    #1;
    push("mid_reset", 32'h0, 1'b0, 32'h0, 1'b0);
    pop_check();
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 0, 0, 0, "reboot", 32'h0, 32'h0, 0);
    step(1, 0, 0, 0, 0, "no_pend", 32'h4, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
